// File: rtl/axi2mem_pkg.sv
// Shared AXI burst definitions and the AXI next-beat address function used by the
// read and write burst generators of axi2mem.
`default_nettype none

package axi2mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam int TCDM_LANES      = 2;
  localparam int TCDM_WORD_BYTES = 4;
  localparam int BEAT_ADDR_LSB   = 3;
  localparam logic [2:0] MAX_SIZE = 3'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_e;

  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > MAX_SIZE) ? MAX_SIZE : size;
  endfunction

  // Computed at 64 bits; callers truncate to their own address width, which also
  // gives INCR its modulo-2^ADDR_WIDTH wrap.
  function automatic logic [63:0] axi_next_addr(input logic [63:0] addr,
                                                 input logic [7:0]  len,
                                                 input logic [2:0]  size,
                                                 input logic [1:0]  burst);
    logic [2:0]  sz;
    logic [63:0] step;
    logic [63:0] aligned;
    logic [63:0] span;
    logic [63:0] low;
    logic        wrap_ok;
    sz      = clamp_size(size);
    step    = 64'd1 << sz;
    aligned = addr & ~(step - 64'd1);
    span    = ({56'd0, len} + 64'd1) << sz;
    low     = aligned & ~(span - 64'd1);
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    if (burst == BURST_FIXED) begin
      return aligned;
    end else if ((burst == BURST_WRAP) && wrap_ok) begin
      return low | ((aligned + step) & (span - 64'd1));
    end
    return aligned + step;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi2mem_rd_burst_gen.sv
// AXI4 AR stage of axi2mem: expands one read burst into 64-bit beats, each issued as
// two independent 32-bit TCDM read commands (lane0 low word, lane1 high word).
`default_nettype none

module axi2mem_rd_burst_gen
  import axi2mem_pkg::*;
#(
  parameter int ID_WIDTH   = 6,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       ar_valid_i,
  output logic                       ar_ready_o,
  input  logic [ADDR_WIDTH-1:0]      ar_addr_i,
  input  logic [7:0]                 ar_len_i,
  input  logic [2:0]                 ar_size_i,
  input  logic [1:0]                 ar_burst_i,
  input  logic [ID_WIDTH-1:0]        ar_id_i,
  output logic [1:0]                 trans_rd_req_o,
  input  logic [1:0]                 trans_rd_gnt_i,
  output logic [1:0][ADDR_WIDTH-1:0] trans_rd_add_o,
  output logic [1:0][ID_WIDTH-1:0]   trans_rd_id_o,
  output logic [1:0]                 trans_rd_last_o
);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] lane0_addr;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [1:0]            sent_q;
  logic [1:0]            lane_done;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  in_burst;
  logic                  ar_hs;
  logic                  beat_done;
  logic                  last_beat;

  assign in_burst  = (state_q == ST_BURST);
  assign ar_hs     = (state_q == ST_IDLE) && ar_valid_i;
  assign last_beat = (cnt_q == len_q);

  // A lane still requesting is exactly a lane with sent clear, so a grant on it
  // completes it; this keeps gnt off the req path entirely.
  assign lane_done = sent_q | trans_rd_gnt_i;
  assign beat_done = in_burst && (&lane_done);

  assign next_addr = ADDR_WIDTH'(axi_next_addr(64'(addr_q), len_q, size_q, burst_q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ar_ready_o     = 1'b0;
    trans_rd_req_o = 2'b00;
    unique case (state_q)
      ST_IDLE: begin
        ar_ready_o = 1'b1;
        if (ar_valid_i) begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        trans_rd_req_o = ~sent_q;
        if (beat_done && last_beat) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      sent_q  <= '0;
    end else if (ar_hs) begin
      addr_q  <= ar_addr_i;
      len_q   <= ar_len_i;
      size_q  <= clamp_size(ar_size_i);
      burst_q <= ar_burst_i;
      id_q    <= ar_id_i;
      cnt_q   <= '0;
      sent_q  <= '0;
    end else if (beat_done) begin
      sent_q  <= '0;
      cnt_q   <= cnt_q + 8'd1;
      addr_q  <= next_addr;
    end else if (in_burst) begin
      sent_q  <= lane_done;
    end
  end

  assign lane0_addr = {addr_q[ADDR_WIDTH-1:BEAT_ADDR_LSB], 3'b000};

  always_comb begin
    trans_rd_add_o  = '0;
    trans_rd_id_o   = '0;
    trans_rd_last_o = 2'b00;
    if (in_burst) begin
      trans_rd_add_o[0] = lane0_addr;
      trans_rd_add_o[1] = lane0_addr + ADDR_WIDTH'(TCDM_WORD_BYTES);
      trans_rd_id_o[0]  = id_q;
      trans_rd_id_o[1]  = id_q;
      trans_rd_last_o   = {2{last_beat}};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi2mem_rd_burst_gen.sv
// Self-checking bench for axi2mem_rd_burst_gen: directed bursts plus randomized bursts
// and grants, checked against a beat-address list model.
`default_nettype none

module tb_axi2mem_rd_burst_gen;

  localparam int ID_WIDTH   = 6;
  localparam int ADDR_WIDTH = 32;

  logic                       clk_i = 1'b0;
  logic                       rst_ni;
  logic                       ar_valid_i;
  logic                       ar_ready_o;
  logic [ADDR_WIDTH-1:0]      ar_addr_i;
  logic [7:0]                 ar_len_i;
  logic [2:0]                 ar_size_i;
  logic [1:0]                 ar_burst_i;
  logic [ID_WIDTH-1:0]        ar_id_i;
  logic [1:0]                 trans_rd_req_o;
  logic [1:0]                 trans_rd_gnt_i;
  logic [1:0][ADDR_WIDTH-1:0] trans_rd_add_o;
  logic [1:0][ID_WIDTH-1:0]   trans_rd_id_o;
  logic [1:0]                 trans_rd_last_o;

  int n_tests = 0;
  int n_fail  = 0;

  longint unsigned exp_lane0[$];

  always #5 clk_i = ~clk_i;

  axi2mem_rd_burst_gen #(
    .ID_WIDTH  (ID_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .ar_valid_i     (ar_valid_i),
    .ar_ready_o     (ar_ready_o),
    .ar_addr_i      (ar_addr_i),
    .ar_len_i       (ar_len_i),
    .ar_size_i      (ar_size_i),
    .ar_burst_i     (ar_burst_i),
    .ar_id_i        (ar_id_i),
    .trans_rd_req_o (trans_rd_req_o),
    .trans_rd_gnt_i (trans_rd_gnt_i),
    .trans_rd_add_o (trans_rd_add_o),
    .trans_rd_id_o  (trans_rd_id_o),
    .trans_rd_last_o(trans_rd_last_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Lane0 word address of every beat, from the AXI address rules.
  function automatic void build_model(input logic [31:0] addr, input int len,
                                      input int size, input int burst);
    longint unsigned a, bytes, span, base;
    int sz;
    sz    = (size > 3) ? 3 : size;
    bytes = longint'(1) << sz;
    a     = addr;
    exp_lane0.delete();
    for (int i = 0; i <= len; i++) begin
      exp_lane0.push_back((a / 8) * 8);
      a = a - (a % bytes);
      if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
        span = longint'(len + 1) * bytes;
        base = (a / span) * span;
        a    = base + ((a - base + bytes) % span);
      end else if (burst != 0) begin
        a = (a + bytes) % 64'h1_0000_0000;
      end
    end
  endfunction

  task automatic drive_ar(input logic [31:0] addr, input int len, input int size,
                          input int burst, input logic [5:0] id);
    ar_valid_i = 1'b1;
    ar_addr_i  = addr;
    ar_len_i   = 8'(len);
    ar_size_i  = 3'(size);
    ar_burst_i = 2'(burst);
    ar_id_i    = id;
  endtask

  // gmode 0: both grants high; 1: random grants; 2: lane1 held off 3 cycles.
  // cont: AR already presented at the current negedge by a back-to-back predecessor.
  task automatic run_burst(input logic [31:0] addr, input int len, input int size,
                           input int burst, input logic [5:0] id, input int gmode,
                           input bit cont, input bit b2b,
                           input logic [31:0] naddr, input int nlen, input int nsize,
                           input int nburst, input logic [5:0] nid);
    int c[2];
    int cyc;
    int beat;
    logic [1:0] exp_req;
    logic [1:0] g;
    build_model(addr, len, size, burst);
    if (!cont) @(negedge clk_i);
    check("idle_ar_ready", ar_ready_o, 1);
    check("idle_no_req", trans_rd_req_o, 0);
    drive_ar(addr, len, size, burst, id);
    c[0] = 0;
    c[1] = 0;
    cyc  = 0;
    forever begin
      @(negedge clk_i);
      if (b2b) drive_ar(naddr, nlen, nsize, nburst, nid);
      else ar_valid_i = 1'b0;
      beat = (c[0] < c[1]) ? c[0] : c[1];
      if (beat == len + 1) begin
        check("done_no_req", trans_rd_req_o, 0);
        check("done_ar_ready", ar_ready_o, 1);
        trans_rd_gnt_i = 2'b00;
        break;
      end
      if (cyc >= 4000) begin
        check("burst_timeout", 1, 0);
        trans_rd_gnt_i = 2'b00;
        break;
      end
      check("busy_ar_ready", ar_ready_o, 0);
      for (int k = 0; k < 2; k++) exp_req[k] = (c[k] == beat);
      check("req", trans_rd_req_o, exp_req);
      case (gmode)
        0:       g = 2'b11;
        2:       g = {(cyc >= 3), 1'b1};
        default: g = {($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0)};
      endcase
      trans_rd_gnt_i = g;
      for (int k = 0; k < 2; k++) begin
        if (trans_rd_req_o[k] && g[k]) begin
          if (c[k] <= len) begin
            check($sformatf("add_l%0d_b%0d", k, c[k]), trans_rd_add_o[k],
                  exp_lane0[c[k]] + longint'(4 * k));
            check($sformatf("last_l%0d_b%0d", k, c[k]), trans_rd_last_o[k], (c[k] == len));
            check($sformatf("id_l%0d", k), trans_rd_id_o[k], id);
          end else begin
            check("lane_overrun", 1, 0);
          end
          c[k]++;
        end
      end
      cyc++;
    end
  endtask

  initial begin
    logic [31:0] pa, na;
    int pl, ps, pb, nl, ns, nb;
    logic [5:0] pid, nid;
    bit cont, b2b;

    rst_ni         = 1'b0;
    ar_valid_i     = 1'b0;
    ar_addr_i      = '0;
    ar_len_i       = '0;
    ar_size_i      = '0;
    ar_burst_i     = '0;
    ar_id_i        = '0;
    trans_rd_gnt_i = 2'b00;
    repeat (3) @(negedge clk_i);
    check("rst_ar_ready", ar_ready_o, 1);
    check("rst_req", trans_rd_req_o, 0);
    check("rst_add", trans_rd_add_o, 0);
    check("rst_id", trans_rd_id_o, 0);
    check("rst_last", trans_rd_last_o, 0);
    rst_ni = 1'b1;

    run_burst(32'h1000, 3, 3, 1, 6'd1, 0, 0, 0, 0, 0, 0, 0, 0);   // INCR
    run_burst(32'h1018, 3, 3, 2, 6'd2, 0, 0, 0, 0, 0, 0, 0, 0);   // WRAP
    run_burst(32'h1000, 1, 3, 1, 6'd3, 2, 0, 0, 0, 0, 0, 0, 0);   // skewed grant
    run_burst(32'h2004, 2, 2, 0, 6'd4, 0, 0, 0, 0, 0, 0, 0, 0);   // narrow FIXED
    run_burst(32'h1010, 0, 7, 3, 6'd5, 0, 0, 0, 0, 0, 0, 0, 0);   // len 0, size clamp, reserved
    run_burst(32'h4000, 3, 3, 1, 6'd10, 1, 0, 1, 32'h5008, 1, 3, 2, 6'd11);
    run_burst(32'h5008, 1, 3, 2, 6'd11, 0, 1, 0, 0, 0, 0, 0, 0);

    // Reset during beat 2 of an 8-beat burst.
    @(negedge clk_i);
    drive_ar(32'h3000, 7, 3, 1, 6'd20);
    trans_rd_gnt_i = 2'b11;
    @(negedge clk_i);
    ar_valid_i = 1'b0;
    check("rs_beat0_req", trans_rd_req_o, 2'b11);
    @(negedge clk_i);
    @(negedge clk_i);
    check("rs_beat2_add", trans_rd_add_o[0], 32'h3010);
    rst_ni = 1'b0;
    #1;
    check("rs_req_drop", trans_rd_req_o, 0);
    check("rs_ar_ready", ar_ready_o, 1);
    check("rs_last", trans_rd_last_o, 0);
    trans_rd_gnt_i = 2'b00;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_burst(32'h3000, 7, 3, 1, 6'd21, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized bursts, some chained back-to-back.
    pa   = $urandom;
    pl   = $urandom_range(0, 15);
    ps   = $urandom_range(0, 7);
    pb   = $urandom_range(0, 3);
    pid  = 6'($urandom);
    cont = 1'b0;
    for (int i = 0; i < 60; i++) begin
      na  = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFC0 + $urandom_range(0, 63)) : $urandom;
      nl  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      ns  = $urandom_range(0, 7);
      nb  = $urandom_range(0, 3);
      nid = 6'($urandom);
      b2b = ($urandom_range(0, 2) == 0);
      run_burst(pa, pl, ps, pb, pid, ($urandom_range(0, 3) == 0) ? 0 : 1, cont, b2b,
                na, nl, ns, nb, nid);
      cont = b2b;
      pa   = na;
      pl   = nl;
      ps   = ns;
      pb   = nb;
      pid  = nid;
    end
    run_burst(pa, pl, ps, pb, pid, 1, cont, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
